barrel_shift_stage: RTL and testbench

//   Buffered, handshaked front end for the 32-bit combinational barrel_shifter.
//   - Accepts shift requests {data, amount, direction} on a valid/ready port.
//   - Queues them in a DEPTH-entry FIFO and drives the head entry into an

---
 rtl/barrel_shift_stage_if.sv | 38 +++
 rtl/barrel_shift_stage.sv | 139 +++++++++++++
 tb/tb_barrel_shift_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/barrel_shift_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : barrel_shift_stage_if
//  Purpose  : Bundles the request port, result port and status outputs of
//             barrel_shift_stage.
//  Signals  : in_valid/in_ready/in_data/in_amt/in_dir   request handshake
//             out_valid/out_ready/out_data              result handshake
//             fifo_count                                requests queued
//             op_count                                  completed results
//  Modports : master - producer/consumer side, slave - shift stage side
//  Revision : 1.0  initial release
// ============================================================================
interface barrel_shift_stage_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic [31:0]              in_data;
   logic [4:0]               in_amt;
   logic                     in_dir;
   logic                     out_valid;
   logic                     out_ready;
   logic [31:0]              out_data;
   logic [$clog2(DEPTH):0]   fifo_count;
   logic [CNT_W-1:0]         op_count;

   modport master (
      output in_valid, in_data, in_amt, in_dir, out_ready,
      input  in_ready, out_valid, out_data, fifo_count, op_count
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_dir, out_ready,
      output in_ready, out_valid, out_data, fifo_count, op_count
   );
endinterface
`default_nettype wire

// File: rtl/barrel_shift_stage.sv
`default_nettype none
// ============================================================================
//  Module   : barrel_shifter
//  Purpose  : 32-bit combinational logical shifter, zero fill both ways.
//  Ports    : i_data  operand, i_amt shift amount 0..31,
//             i_dir   0 = left, 1 = right, o_data shifted result
//  Revision : 1.0  initial release
// ============================================================================
module barrel_shifter (
   input  wire logic [31:0] i_data,
   input  wire logic [4:0]  i_amt,
   input  wire logic        i_dir,
   output logic      [31:0] o_data
);
   logic [31:0] w_acc;

   // Logarithmic structure: stage k shifts by 2^k when amount bit k is set.
   always_comb begin
      w_acc = i_data;
      for (int k = 0; k < 5; k++) begin
         if (i_amt[k]) begin
            w_acc = i_dir ? (w_acc >> (1 << k)) : (w_acc << (1 << k));
         end
      end
   end

   assign o_data = w_acc;
endmodule

// ============================================================================
//  Module   : barrel_shift_stage
//  Purpose  : Buffered valid/ready front end for barrel_shifter. Requests
//             are queued in a DEPTH-entry FIFO; the head entry is shifted
//             and captured in a registered output stage.
//  Ports    : clk        rising-edge clock
//             rst        synchronous active-high reset
//             bus.slave  request port, result port, fifo_count, op_count
//  Params   : DEPTH  FIFO entries (power of two, >= 2)
//             CNT_W  completed-operation counter width
//  Revision : 1.0  initial release
// ============================================================================
module barrel_shift_stage #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  wire logic             clk,
   input  wire logic             rst,
   barrel_shift_stage_if.slave   bus
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_FW = PTR_W + 1;
   localparam int ENT_W  = 38;
   localparam logic [CNT_FW-1:0] c_DEPTH = CNT_FW'(DEPTH);

   logic [ENT_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_FW-1:0] r_count;
   logic              r_out_valid;
   logic [31:0]       r_out_data;
   logic [CNT_W-1:0]  r_op_count;

   logic              w_in_ready;
   logic              w_push;
   logic              w_pop;
   logic              w_out_hs;
   logic [ENT_W-1:0]  w_head;
   logic [31:0]       w_shift;

   // Readiness depends only on the occupancy register, so no combinational
   // path exists from out_ready back to in_ready.
   assign w_in_ready = (r_count != c_DEPTH);
   assign w_push     = bus.in_valid && w_in_ready;
   assign w_out_hs   = r_out_valid && bus.out_ready;
   // The output register may be refilled when empty or being drained now.
   assign w_pop      = (r_count != '0) && (!r_out_valid || bus.out_ready);
   assign w_head     = r_mem[r_rd_ptr];

   barrel_shifter u_shifter (
      .i_data (w_head[37:6]),
      .i_amt  (w_head[5:1]),
      .i_dir  (w_head[0]),
      .o_data (w_shift)
   );

   // Storage carries no reset: pointers and count define which entries live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {bus.in_data, bus.in_amt, bus.in_dir};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_FW'(1);
            2'b01:   r_count <= r_count - CNT_FW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_pop) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_shift;
      end else if (w_out_hs) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op_count <= '0;
      end else if (w_out_hs) begin
         r_op_count <= r_op_count + CNT_W'(1);
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_data   = r_out_data;
   assign bus.fifo_count = r_count;
   assign bus.op_count   = r_op_count;
endmodule
`default_nettype wire

// File: tb/tb_barrel_shift_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_barrel_shift_stage
//  Purpose  : Self-checking bench for barrel_shift_stage: directed cases with
//             literal expectations plus randomized traffic against a
//             queue-based reference model compared every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_barrel_shift_stage;
   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   barrel_shift_stage_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   barrel_shift_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] shift_ref(input logic [31:0] d, input logic [4:0] a, input logic dir);
      return dir ? (d >> a) : (d << a);
   endfunction

   // Reference model: a queue of pending requests plus one output slot.
   logic [37:0]      mq[$];
   logic             m_valid = 1'b0;
   logic [31:0]      m_data  = '0;
   logic [CNT_W-1:0] m_ops   = '0;
   bit               m_live  = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_valid = 1'b0;
         m_data  = '0;
         m_ops   = '0;
         m_live  = 1'b1;
      end else if (m_live) begin
         logic        hs, push, pop;
         logic [37:0] e;
         hs   = m_valid && bus.out_ready;
         push = bus.in_valid && (mq.size() < DEPTH);
         pop  = (mq.size() != 0) && (!m_valid || bus.out_ready);
         if (hs) m_ops = m_ops + 1'b1;
         if (pop) begin
            e       = mq.pop_front();
            m_data  = shift_ref(e[37:6], e[5:1], e[0]);
            m_valid = 1'b1;
         end else if (hs) begin
            m_valid = 1'b0;
         end
         if (push) mq.push_back({bus.in_data, bus.in_amt, bus.in_dir});
      end
   end

   always @(negedge clk) begin
      if (m_live && !rst) begin
         check("model in_ready",   32'(bus.in_ready),   32'(mq.size() < DEPTH));
         check("model fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
         check("model out_valid",  32'(bus.out_valid),  32'(m_valid));
         check("model out_data",   bus.out_data,        m_data);
         check("model op_count",   32'(bus.op_count),   32'(m_ops));
      end
   end

   task automatic send_one(input logic [31:0] d, input logic [4:0] a, input logic dir,
                           input logic [31:0] exp, input string name);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_amt    = a;
      bus.in_dir    = dir;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check({name, " accepted count"}, 32'(bus.fifo_count), 32'd1);
      @(negedge clk);
      check({name, " valid"}, 32'(bus.out_valid), 32'd1);
      check(name, bus.out_data, exp);
   endtask

   task automatic pulse_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   logic [31:0] held;
   int          accepted;
   int          cyc;

   initial begin
      // 1. Reset with in_valid held high
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h1234_5678;
      bus.in_amt    = 5'd3;
      bus.in_dir    = 1'b0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset out_valid",  32'(bus.out_valid),  32'd0);
      check("reset in_ready",   32'(bus.in_ready),   32'd1);
      check("reset fifo_count", 32'(bus.fifo_count), 32'd0);
      check("reset op_count",   32'(bus.op_count),   32'd0);
      check("reset out_data",   bus.out_data,        32'd0);
      rst          = 1'b0;
      bus.in_valid = 1'b0;

      // 2. Single operations
      send_one(32'h8000_0001, 5'd1,  1'b0, 32'h0000_0002, "single left");
      send_one(32'h8000_0001, 5'd1,  1'b1, 32'h4000_0000, "single right");
      // 3. Boundaries
      send_one(32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, "amt0");
      send_one(32'hFFFF_FFFF, 5'd31, 1'b1, 32'h0000_0001, "amt31 right");
      send_one(32'h0000_0003, 5'd31, 1'b0, 32'h8000_0000, "amt31 left");

      // 4. Backpressure: six offers, five fit
      pulse_reset(1);
      bus.out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'h100 + k;
         bus.in_amt   = 5'(k);
         bus.in_dir   = 1'b0;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check("full in_ready",   32'(bus.in_ready),   32'd0);
      check("full fifo_count", 32'(bus.fifo_count), 32'd4);
      held = bus.out_data;
      repeat (3) @(negedge clk);
      check("hold out_data",  bus.out_data,        held);
      check("hold out_valid", 32'(bus.out_valid),  32'd1);
      check("drain first",    bus.out_data,        32'h100);
      bus.out_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         @(negedge clk);
         check("drain valid", 32'(bus.out_valid), 32'd1);
         check("drain order", bus.out_data, (32'h100 + 32'(k)) << k);
      end
      @(negedge clk);
      check("drain done valid", 32'(bus.out_valid), 32'd0);
      check("drain op_count",   32'(bus.op_count),  32'd5);

      // 5. Simultaneous push and pop at fifo_count == 2
      pulse_reset(1);
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'hA0 + k;
         bus.in_amt   = 5'd4;
         bus.in_dir   = 1'b1;
         @(negedge clk);
      end
      check("simul pre count", 32'(bus.fifo_count), 32'd2);
      bus.in_data   = 32'hF000_0000;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("simul count", 32'(bus.fifo_count), 32'd2);
      check("simul valid", 32'(bus.out_valid),  32'd1);
      check("simul data",  bus.out_data,        32'h0000_000A);
      repeat (4) @(negedge clk);
      check("simul empty", 32'(bus.out_valid), 32'd0);

      // 6. Reset with 3 queued and 1 held
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'h55 + k;
         bus.in_amt   = 5'd0;
         bus.in_dir   = 1'b0;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check("pre-reset count", 32'(bus.fifo_count), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset valid", 32'(bus.out_valid),  32'd0);
      check("midreset count", 32'(bus.fifo_count), 32'd0);
      bus.out_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("no stale result", 32'(bus.out_valid), 32'd0);
      end

      // Randomized traffic against the model
      accepted = 0;
      cyc      = 0;
      while (accepted < 200 && cyc < 5000) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_data   = $urandom;
         bus.in_amt    = 5'($urandom_range(0, 31));
         bus.in_dir    = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 2) != 0);
         if (bus.in_valid && bus.in_ready) accepted++;
         @(negedge clk);
         cyc++;
      end
      check("random accepted", 32'(accepted), 32'd200);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      cyc = 0;
      while ((bus.out_valid || bus.fifo_count != 0) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("random drained", 32'(bus.out_valid || bus.fifo_count != 0), 32'd0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
